// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - two-digit multiplexed common-anode 7-segment scan driver
//
// Purpose: snapshots the BCD units/tens digits once per scan frame, alternates
// the two digits every SCAN_DIV clocks and decodes BCD to active-low segments,
// with optional leading-zero blanking of the tens digit and a snapshot hold.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   reset    in  1  asynchronous, active-high reset
//   dv       in  4  BCD units digit
//   ch       in  4  BCD tens digit
//   blank_lz in  1  blank the tens digit when its snapshot is 0
//   hold     in  1  freeze the snapshot at frame start
//   seg      out 7  segments {g,f,e,d,c,b,a}, active-low
//   an       out 2  digit enables, active-low; an[0] units, an[1] tens
module seg7_scan_driver #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dv,
  input  logic [3:0] ch,
  input  logic       blank_lz,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [3:0]    snap_dv_q, snap_dv_d;
  logic [3:0]    snap_ch_q, snap_ch_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic tick;
  logic load;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_MAX);
  // Frame start is the tick that leaves the tens slot (sel_q == 1).
  assign load = tick && sel_q && !hold;

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    sel_d     = tick ? ~sel_q : sel_q;
    snap_dv_d = load ? dv : snap_dv_q;
    snap_ch_d = load ? ch : snap_ch_q;
    seg_d     = seg_q;
    an_d      = an_q;
    // Outputs follow the new slot and new snapshot, so a freshly captured
    // units digit is shown on its capture edge.
    if (tick) begin
      if (!sel_d) begin
        an_d  = AN_UNITS;
        seg_d = decode(snap_dv_d);
      end else if (blank_lz && (snap_ch_d == 4'd0)) begin
        an_d  = AN_OFF;
        seg_d = SEG_DARK;
      end else begin
        an_d  = AN_TENS;
        seg_d = decode(snap_ch_d);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sel_q     <= 1'b1;
      snap_dv_q <= 4'd0;
      snap_ch_q <= 4'd0;
      seg_q     <= SEG_DARK;
      an_q      <= AN_OFF;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      snap_dv_q <= snap_dv_d;
      snap_ch_q <= snap_ch_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] dv;
  logic [3:0] ch;
  logic       blank_lz;
  logic       hold;
  logic [6:0] seg;
  logic [1:0] an;

  int total;
  int bad;
  int e;

  seg7_scan_driver #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dv       (dv),
    .ch       (ch),
    .blank_lz (blank_lz),
    .hold     (hold),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] exp_an, input logic [6:0] exp_seg);
    total++;
    assert ({an, seg} === {exp_an, exp_seg}) else begin
      bad++;
      $error("FAIL %s observed an=%b seg=%h expected an=%b seg=%h", tag, an, seg, exp_an, exp_seg);
    end
  endtask

  task automatic go_to(input int target);
    while (e < target) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  // At most one digit may ever be enabled.
  always @(negedge clk) begin
    total++;
    assert (an !== 2'b00) else begin
      bad++;
      $error("FAIL an_never_both observed an=%b expected not 00 at edge %0d", an, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    e = 0;
    reset = 1'b1;
    dv = 4'd7;
    ch = 4'd4;
    blank_lz = 1'b0;
    hold = 1'b0;
    #1;
    chk("reset_state", 2'b11, 7'h7F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset release: dark until edge 4, units 7, tens 4 at edge 8.
    go_to(1);  chk("rel_e1", 2'b11, 7'h7F);
    go_to(2);  chk("rel_e2", 2'b11, 7'h7F);
    go_to(3);  chk("rel_e3", 2'b11, 7'h7F);
    go_to(4);  chk("rel_e4_units", 2'b10, 7'h78);
    go_to(7);  chk("rel_e7_units_held", 2'b10, 7'h78);
    go_to(8);  chk("rel_e8_tens", 2'b01, 7'h19);
    go_to(12); chk("rel_e12_units", 2'b10, 7'h78);

    // Tear-free capture: 9/5 captured at edge 20, inputs zeroed at edge 22.
    ch = 4'd5; dv = 4'd9;
    go_to(20); chk("tear_units", 2'b10, 7'h10);
    go_to(22);
    ch = 4'd0; dv = 4'd0;
    go_to(24); chk("tear_tens_still_5", 2'b01, 7'h12);
    go_to(28); chk("tear_next_units", 2'b10, 7'h40);
    go_to(32); chk("tear_next_tens", 2'b01, 7'h40);

    // Leading-zero blank.
    blank_lz = 1'b1; ch = 4'd0; dv = 4'd3;
    go_to(36); chk("lz_units", 2'b10, 7'h30);
    go_to(40); chk("lz_tens_blank", 2'b11, 7'h7F);
    blank_lz = 1'b0;
    go_to(44); chk("lz_off_units", 2'b10, 7'h30);
    go_to(48); chk("lz_off_tens", 2'b01, 7'h40);

    // Hold: show 2/3, freeze, change inputs to 5/9.
    dv = 4'd3; ch = 4'd2;
    go_to(52); chk("hold_pre_units", 2'b10, 7'h30);
    go_to(56); chk("hold_pre_tens", 2'b01, 7'h24);
    hold = 1'b1; dv = 4'd9; ch = 4'd5;
    go_to(60); chk("hold_f1_units", 2'b10, 7'h30);
    go_to(64); chk("hold_f1_tens", 2'b01, 7'h24);
    go_to(68); chk("hold_f2_units", 2'b10, 7'h30);
    go_to(72); chk("hold_f2_tens", 2'b01, 7'h24);
    go_to(76); chk("hold_f3_units", 2'b10, 7'h30);
    go_to(80); chk("hold_f3_tens", 2'b01, 7'h24);
    hold = 1'b0;
    go_to(84); chk("unhold_units", 2'b10, 7'h10);
    go_to(88); chk("unhold_tens", 2'b01, 7'h12);

    // Invalid BCD shows a dash.
    dv = 4'd12; ch = 4'd15;
    go_to(92); chk("bad_bcd_units", 2'b10, 7'h3F);
    go_to(96); chk("bad_bcd_tens", 2'b01, 7'h3F);

    // Mid-frame reset during the tens slot.
    go_to(97);
    reset = 1'b1;
    #1;
    chk("midreset_dark_now", 2'b11, 7'h7F);
    dv = 4'd7; ch = 4'd4;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    e = 0;
    go_to(1);  chk("mr_e1", 2'b11, 7'h7F);
    go_to(3);  chk("mr_e3", 2'b11, 7'h7F);
    go_to(4);  chk("mr_e4_units", 2'b10, 7'h78);
    go_to(8);  chk("mr_e8_tens", 2'b01, 7'h19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
